// File: rtl/b_c_solver.sv
// Bulls-only code breaker: walks every unlocked digit upward until a bull
// pins it, then holds it while the remaining digits keep searching.
module b_c_solver #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       score_valid,
    input  logic [3:0] bulls,
    input  logic [3:0] cows,
    output logic [2:0] guess_A,
    output logic [2:0] guess_B,
    output logic [2:0] guess_C,
    output logic [2:0] guess_D,
    output logic       guess_valid,
    output logic [3:0] locked,
    output logic [3:0] attempts,
    output logic [3:0] last_bulls,
    output logic [3:0] last_cows,
    output logic       busy,
    output logic       solved,
    output logic       failed
);

    localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUESS,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][2:0] digit_q, digit_d;
    logic [3:0]      locked_q, locked_d;
    logic [3:0]      attempts_q, attempts_d;
    logic [3:0]      last_bulls_q, last_bulls_d;
    logic [3:0]      last_cows_q, last_cows_d;
    logic            solved_q, solved_d;
    logic            failed_q, failed_d;
    logic            inconsistent;

    // A bull missing on an already-confirmed position means the scorer contradicted itself.
    assign inconsistent = |(locked_q & ~last_bulls_q);

    // State and datapath registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            digit_q      <= '0;
            locked_q     <= '0;
            attempts_q   <= '0;
            last_bulls_q <= '0;
            last_cows_q  <= '0;
            solved_q     <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            locked_q     <= locked_d;
            attempts_q   <= attempts_d;
            last_bulls_q <= last_bulls_d;
            last_cows_q  <= last_cows_d;
            solved_q     <= solved_d;
            failed_q     <= failed_d;
        end
    end

    // Next-state: accept a score in GUESS, judge it in EVAL, restart from any idle state.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        locked_d     = locked_q;
        attempts_d   = attempts_q;
        last_bulls_d = last_bulls_q;
        last_cows_d  = last_cows_q;
        solved_d     = solved_q;
        failed_d     = failed_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    digit_d      = '0;
                    locked_d     = '0;
                    attempts_d   = '0;
                    last_bulls_d = '0;
                    last_cows_d  = '0;
                    solved_d     = 1'b0;
                    failed_d     = 1'b0;
                    state_d      = S_GUESS;
                end
            end
            S_GUESS: begin
                if (score_valid) begin
                    last_bulls_d = bulls;
                    last_cows_d  = cows;
                    attempts_d   = attempts_q + 4'd1;
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                if (inconsistent) begin
                    failed_d = 1'b1;
                    state_d  = S_FAIL;
                end else if (last_bulls_q == 4'b1111) begin
                    locked_d = '1;
                    solved_d = 1'b1;
                    state_d  = S_DONE;
                end else if (attempts_q == TRIES_LIMIT) begin
                    failed_d = 1'b1;
                    state_d  = S_FAIL;
                end else begin
                    // Freshly bulled positions are frozen in the same step they are confirmed.
                    locked_d = locked_q | last_bulls_q;
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (!locked_d[i]) begin
                            digit_d[i] = digit_q[i] + 3'd1;
                        end
                    end
                    state_d = S_GUESS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign guess_A     = digit_q[0];
    assign guess_B     = digit_q[1];
    assign guess_C     = digit_q[2];
    assign guess_D     = digit_q[3];
    assign guess_valid = (state_q == S_GUESS);
    assign busy        = (state_q == S_GUESS) || (state_q == S_EVAL);
    assign locked      = locked_q;
    assign attempts    = attempts_q;
    assign last_bulls  = last_bulls_q;
    assign last_cows   = last_cows_q;
    assign solved      = solved_q;
    assign failed      = failed_q;

endmodule

// File: tb/tb_b_c_solver.sv
// Bench for b_c_solver: a transaction-level model of the solve plus a scorer
// that answers from a secret, with directed scenarios and randomized solves.
module tb_b_c_solver;

    localparam int unsigned MT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, score_valid;
    logic [3:0] bulls, cows;
    logic [2:0] guess_A, guess_B, guess_C, guess_D;
    logic       guess_valid;
    logic [3:0] locked, attempts, last_bulls, last_cows;
    logic       busy, solved, failed;

    b_c_solver #(.MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
        .bulls(bulls), .cows(cows),
        .guess_A(guess_A), .guess_B(guess_B), .guess_C(guess_C), .guess_D(guess_D),
        .guess_valid(guess_valid), .locked(locked), .attempts(attempts),
        .last_bulls(last_bulls), .last_cows(last_cows),
        .busy(busy), .solved(solved), .failed(failed)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of what the solver must show.
    int         m_g[4];
    logic [3:0] m_locked, m_lb, m_lc;
    int         m_att;
    bit         m_wait_score, m_eval, m_solved, m_failed;

    // Scorer / stimulus controls.
    int secret[4];
    int mode;          // 0 honest, 1 always zero, 2 deny bull A once locked, 3 random bulls
    int delay_cnt;
    bit noise, rand_delay, force_sv, cmp_en;
    int lock_at[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_g[i] = 0;
        m_locked = '0; m_lb = '0; m_lc = '0; m_att = 0;
        m_wait_score = 0; m_eval = 0; m_solved = 0; m_failed = 0;
    endtask

    // Apply the solve rules to whatever inputs were present at the edge just taken.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_eval) begin
            m_eval = 0;
            if ((m_locked & ~m_lb) != 4'b0000) m_failed = 1;
            else if (m_lb == 4'b1111) begin m_solved = 1; m_locked = 4'b1111; end
            else if (m_att == int'(MT)) m_failed = 1;
            else begin
                m_locked = m_locked | m_lb;
                for (int i = 0; i < 4; i++) if (!m_locked[i]) m_g[i] = (m_g[i] + 1) % 8;
                m_wait_score = 1;
            end
        end else if (m_wait_score) begin
            if (score_valid) begin
                m_lb = bulls; m_lc = cows; m_att++;
                m_wait_score = 0; m_eval = 1;
            end
        end else if (start) begin
            model_reset();
            m_wait_score = 1;
        end
    endtask

    task automatic score_guess();
        logic [3:0] b, c;
        b = '0; c = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_g[i] == secret[i]) b[i] = 1'b1;
            else for (int j = 0; j < 4; j++) if (j != i && secret[j] == m_g[i]) c[i] = 1'b1;
        end
        case (mode)
            1: begin b = '0; c = '0; end
            2: if (m_locked[0]) b[0] = 1'b0;
            3: b = 4'($urandom);
            default: ;
        endcase
        bulls = b; cows = c;
    endtask

    task automatic drive_next();
        start = 1'b0; score_valid = 1'b0;
        bulls = 4'($urandom); cows = 4'($urandom);
        if (m_wait_score) begin
            if (delay_cnt == 0) begin
                score_valid = 1'b1;
                score_guess();
                if (noise && $urandom_range(0, 1) == 1) start = 1'b1;
            end else begin
                delay_cnt--;
                if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
            end
        end else begin
            if (noise) begin
                score_valid = 1'($urandom_range(0, 1));
                if (m_eval) start = 1'($urandom_range(0, 1));
            end
            if (force_sv) score_valid = 1'b1;
        end
    endtask

    task automatic cycle();
        bit was_wait;
        @(posedge clk);
        #1;
        was_wait = m_wait_score;
        model_edge();
        if (!was_wait && m_wait_score) delay_cnt = rand_delay ? int'($urandom_range(0, 3)) : 1;
        drive_next();
    endtask

    task automatic begin_solve();
        start = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) lock_at[i] = -1;
    endtask

    task automatic finish_solve(input string tag);
        for (int n = 0; n < 200 && !(m_solved || m_failed); n++) cycle();
        chk({tag, "_ends"}, 32'(m_solved || m_failed), 1);
        cycle();
    endtask

    // Per-cycle comparison against the model, plus lock-order bookkeeping.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("guess_A", 32'(guess_A), m_g[0]);
            chk("guess_B", 32'(guess_B), m_g[1]);
            chk("guess_C", 32'(guess_C), m_g[2]);
            chk("guess_D", 32'(guess_D), m_g[3]);
            chk("guess_valid", 32'(guess_valid), 32'(m_wait_score));
            chk("busy", 32'(busy), 32'(m_wait_score || m_eval));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("attempts", 32'(attempts), m_att);
            chk("last_bulls", 32'(last_bulls), 32'(m_lb));
            chk("last_cows", 32'(last_cows), 32'(m_lc));
            chk("solved", 32'(solved), 32'(m_solved));
            chk("failed", 32'(failed), 32'(m_failed));
            for (int i = 0; i < 4; i++) if (locked[i] === 1'b1 && lock_at[i] < 0) lock_at[i] = int'(attempts);
        end
    end

    initial begin
        start = 1'b0; score_valid = 1'b0; bulls = '0; cows = '0;
        noise = 0; rand_delay = 0; force_sv = 0; cmp_en = 0; mode = 0; delay_cnt = 0;
        for (int i = 0; i < 4; i++) begin lock_at[i] = -1; secret[i] = 0; end
        model_reset();

        // Reset state, visible before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_all_outputs", {guess_A, guess_B, guess_C, guess_D, guess_valid, locked, attempts,
                                last_bulls, last_cows, busy, solved, failed}, 0);
        cmp_en = 1;
        cycle(); cycle();
        #2 rst = 1'b0;
        cycle(); cycle(); cycle();
        chk("no_guess_without_start", 32'(guess_valid), 0);

        // Secret 5,2,7,0 with a scorer that answers promptly.
        mode = 0; secret = '{5, 2, 7, 0};
        begin_solve();
        finish_solve("s5270");
        chk("s5270_solved", 32'(solved), 1);
        chk("s5270_attempts", 32'(attempts), 8);
        chk("s5270_guess", 32'({guess_A, guess_B, guess_C, guess_D}), 32'({3'd5, 3'd2, 3'd7, 3'd0}));
        chk("s5270_locked", 32'(locked), 32'hF);
        chk("s5270_lockA", lock_at[0], 6);
        chk("s5270_lockB", lock_at[1], 3);
        chk("s5270_lockC", lock_at[2], 8);
        chk("s5270_lockD", lock_at[3], 1);

        // Secret 0,0,0,0 solves on the first score.
        secret = '{0, 0, 0, 0};
        begin_solve();
        finish_solve("s0000");
        chk("s0000_attempts", 32'(attempts), 1);
        chk("s0000_solved", 32'(solved), 1);
        chk("s0000_bulls", 32'(last_bulls), 32'hF);

        // Restart from DONE, then a start during GUESS that must be ignored.
        start = 1'b1;
        cycle();
        chk("restart_gv", 32'(guess_valid), 1);
        chk("restart_attempts", 32'(attempts), 0);
        chk("restart_guess", 32'({guess_A, guess_B, guess_C, guess_D}), 0);
        chk("restart_solved", 32'(solved), 0);
        delay_cnt = 5; start = 1'b1;
        cycle();
        chk("start_in_guess_gv", 32'(guess_valid), 1);
        chk("start_in_guess_attempts", 32'(attempts), 0);
        chk("start_in_guess_busy", 32'(busy), 1);
        finish_solve("restart");

        // Scorer that never reports a bull exhausts the tries.
        mode = 1; secret = '{3, 1, 4, 6};
        begin_solve();
        finish_solve("silent");
        chk("silent_attempts", 32'(attempts), 8);
        chk("silent_guess", 32'({guess_A, guess_B, guess_C, guess_D}), 32'({3'd7, 3'd7, 3'd7, 3'd7}));
        chk("silent_failed", 32'(failed), 1);
        chk("silent_solved", 32'(solved), 0);

        // Scorer withdraws the bull on A after it locked.
        mode = 2; secret = '{5, 2, 7, 0};
        begin_solve();
        finish_solve("liar");
        chk("liar_attempts", 32'(attempts), 7);
        chk("liar_failed", 32'(failed), 1);
        chk("liar_solved", 32'(solved), 0);
        cycle();
        chk("liar_attempts_hold", 32'(attempts), 7);

        // Asynchronous reset in the middle of a solve, then a stray score.
        mode = 1;
        begin_solve();
        repeat (6) cycle();
        for (int n = 0; n < 10 && !m_wait_score; n++) cycle();
        delay_cnt = 100;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_all_outputs", {guess_A, guess_B, guess_C, guess_D, guess_valid, locked, attempts,
                                   last_bulls, last_cows, busy, solved, failed}, 0);
        force_sv = 1; score_valid = 1'b1;
        cycle(); cycle();
        #2 rst = 1'b0;
        cycle(); cycle(); cycle();
        chk("midrst_gv", 32'(guess_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_attempts", 32'(attempts), 0);
        force_sv = 0;

        // Randomized solves with stray start/score activity and variable scorer latency.
        noise = 1; rand_delay = 1;
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0, 1: mode = 0;
                2: mode = 2;
                default: mode = 3;
            endcase
            for (int i = 0; i < 4; i++) secret[i] = int'($urandom_range(0, 7));
            begin_solve();
            finish_solve("rand");
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/b_c_solver.md
B_C_SOLVER -- requirements
Module: b_c_solver

Interface
REQ-001 Parameter: MAX_TRIES, default 8, number of scored guesses allowed before failure; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a new solve.
REQ-005 score_valid  input  1  bulls/cows carry the score of the current guess.
REQ-006 bulls  input  4  per-position exact-match flags; bit0=A, bit3=D.
REQ-007 cows  input  4  per-position wrong-place flags; bit0=A, bit3=D.
REQ-008 guess_A, guess_B, guess_C, guess_D  output  3 each  current guess digits, 0..7.
REQ-009 guess_valid  output  1  guess digits are stable and awaiting a score.
REQ-010 locked  output  4  positions confirmed by a bull; bit0=A.
REQ-011 attempts  output  4  count of scores accepted in the current solve.
REQ-012 last_bulls, last_cows  output  4 each  most recently accepted score.
REQ-013 busy, solved, failed  output  1 each  solve in progress / secret found / solve aborted.

Function
REQ-014 The FSM SHALL have five states: IDLE, GUESS, EVAL, DONE and FAIL.
REQ-015 In IDLE, DONE or FAIL, start SHALL clear guesses, locked, attempts, last_bulls, last_cows, solved and failed, then enter GUESS on the next edge.
REQ-016 In GUESS, guess_valid SHALL be 1 and the guess digits SHALL be held constant.
REQ-017 In GUESS, score_valid=1 SHALL capture bulls/cows into last_bulls/last_cows, increment attempts, and enter EVAL.
REQ-018 While score_valid=0 in GUESS, the block SHALL wait indefinitely; there is no timeout.
REQ-019 score_valid SHALL be ignored in every state except GUESS.
REQ-020 start SHALL be ignored in GUESS and EVAL.
REQ-021 When start and score_valid are both 1 in GUESS, the score SHALL be taken and start SHALL be ignored.
REQ-022 EVAL SHALL last exactly one cycle, with guess_valid=0.
REQ-023 EVAL priority 1: if any locked bit has last_bulls=0 at that position (inconsistent score), the block SHALL enter FAIL.
REQ-024 EVAL priority 2: else, if last_bulls=4'b1111, the block SHALL enter DONE.
REQ-025 EVAL priority 3: else, if attempts==MAX_TRIES, the block SHALL enter FAIL.
REQ-026 EVAL priority 4: else, locked SHALL become locked OR last_bulls, and each still-unlocked digit SHALL increment by 1.
REQ-027 Digit increment SHALL wrap modulo 8 (7 to 0), and locked digits SHALL be held; the block then SHALL return to GUESS.
REQ-028 On entry to DONE, locked SHALL be 4'b1111 and solved SHALL be 1.
REQ-029 On entry to FAIL, failed SHALL be 1.
REQ-030 solved and failed SHALL hold until the next start or reset.
REQ-031 busy SHALL be 1 exactly in GUESS and EVAL.
REQ-032 The round-trip latency from start to first guess_valid SHALL be one cycle.
REQ-033 Each score accepted without ending the solve SHALL produce the next guess_valid two cycles later (EVAL, then GUESS).
REQ-034 cows SHALL affect only last_cows; the solver strategy uses bulls only.

Reset
REQ-035 While rst=1, the state SHALL be IDLE and every output SHALL be 0, including guesses, locked, attempts, last_bulls, last_cows, guess_valid, busy, solved and failed.
REQ-036 Reset asserted mid-solve SHALL abandon the solve immediately, without waiting for a clock edge.
REQ-037 After rst deasserts, no guess SHALL be issued until start.

Verification
REQ-038 Secret 5,2,7,0; the scorer answers one cycle after guess_valid. Required: DONE with guess 5,2,7,0, attempts=8, solved=1, locked order A@6, B@3, C@8, D@1.
REQ-039 Secret 0,0,0,0. Required: the first score gives bulls=1111, then DONE with attempts=1 and solved=1.
REQ-040 Scorer held in save (bulls=cows=0 always), MAX_TRIES=8. Required: FAIL after attempts=8 with guess 7,7,7,7, failed=1 and solved=0.
REQ-041 Secret changed after position A locks, so bulls[0]=0 is reported next. Required: the following EVAL goes to FAIL with failed=1 and attempts unchanged.
REQ-042 rst pulsed mid-GUESS, then score_valid pulsed. Required: all outputs are 0 asynchronously, the state stays IDLE and the score is ignored.
REQ-043 start issued in DONE, and start issued during GUESS. Required: from DONE, attempts=0 and guess 0,0,0,0 with guess_valid one cycle later; during GUESS, start has no effect.
